// File: rtl/rom_port_arbiter_pkg.sv
// Shared encodings for the two-master ROM port arbiter: FSM states, owner codes,
// and the starvation counter width helper.
package rom_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RSP  = 2'd2
    } arb_state_t;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

    localparam int SEL_W = 4;

    // A limit of 0 disables forcing, but the counter still needs a legal width.
    function automatic int cnt_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/rom_port_arbiter_pick.sv
// Combinational winner select for the ROM arbiter (gnt_m1 = m1 wins, any = someone wins).
// Round-robin when ROM_ARB_RR_EN is defined, otherwise fixed m0 priority with starvation override.
module rom_arb_pick
    import rom_port_arbiter_pkg::*;
(
    input  logic m0_valid,
    input  logic m1_valid,
    input  logic rr_last,
    input  logic starve,
    output logic gnt_m1,
    output logic any
);

    assign any = m0_valid | m1_valid;

`ifdef ROM_ARB_RR_EN
    logic unused_starve;
    assign unused_starve = starve;

    // rr_last names the previous winner; on a tie the other master goes
    assign gnt_m1 = m1_valid & (~m0_valid | (rr_last == ARB_M0));
`else
    logic unused_rr;
    assign unused_rr = rr_last;

    assign gnt_m1 = m1_valid & (~m0_valid | starve);
`endif

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one single-ported ROM/RAM slave between instruction fetch (m0) and data port (m1),
// one transaction in flight. Define ROM_ARB_RR_EN for round-robin instead of fixed priority.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [AW-1:0]    m0_addr_i,
    input  logic             m0_req_valid_i,
    output logic             m0_req_ready_o,
    output logic [DW-1:0]    m0_data_o,
    output logic             m0_rsp_valid_o,
    input  logic             m0_rsp_ready_i,

    input  logic [AW-1:0]    m1_addr_i,
    input  logic [DW-1:0]    m1_data_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic             m1_we_i,
    input  logic             m1_req_valid_i,
    output logic             m1_req_ready_o,
    output logic [DW-1:0]    m1_data_o,
    output logic             m1_rsp_valid_o,
    input  logic             m1_rsp_ready_i,

    output logic [AW-1:0]    s_addr_o,
    output logic [DW-1:0]    s_data_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic             s_we_o,
    output logic             s_req_valid_o,
    input  logic             s_req_ready_i,
    input  logic [DW-1:0]    s_data_i,
    input  logic             s_rsp_valid_i,
    output logic             s_rsp_ready_o
);

    localparam int SCW = cnt_width(STARVE_LIMIT);

    arb_state_t     state, state_nxt;
    logic           owner;
    logic           rr_last;
    logic [SCW-1:0] starve_cnt;
    logic           starve;
    logic           gnt_m1;
    logic           any_req;
    logic           grant;
    logic           rsp_rdy;

    assign starve = (STARVE_LIMIT > 0) && (starve_cnt == SCW'(STARVE_LIMIT));

    rom_arb_pick u_pick (
        .m0_valid (m0_req_valid_i),
        .m1_valid (m1_req_valid_i),
        .rr_last  (rr_last),
        .starve   (starve),
        .gnt_m1   (gnt_m1),
        .any      (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        grant          = 1'b0;
        rsp_rdy        = 1'b0;
        m0_req_ready_o = 1'b0;
        m1_req_ready_o = 1'b0;
        m0_rsp_valid_o = 1'b0;
        m1_rsp_valid_o = 1'b0;
        m0_data_o      = '0;
        m1_data_o      = '0;
        s_req_valid_o  = 1'b0;

        case (state)
            ARB_IDLE: begin
                // Anything arriving from the slave here is stale (e.g. issued before reset)
                rsp_rdy = 1'b1;
                if (any_req) begin
                    grant          = 1'b1;
                    m0_req_ready_o = ~gnt_m1;
                    m1_req_ready_o = gnt_m1;
                    state_nxt      = ARB_REQ;
                end
            end
            ARB_REQ: begin
                s_req_valid_o = 1'b1;
                if (s_req_ready_i) state_nxt = ARB_RSP;
            end
            ARB_RSP: begin
                if (owner == ARB_M1) begin
                    m1_rsp_valid_o = s_rsp_valid_i;
                    m1_data_o      = s_data_i;
                    rsp_rdy        = m1_rsp_ready_i;
                end else begin
                    m0_rsp_valid_o = s_rsp_valid_i;
                    m0_data_o      = s_data_i;
                    rsp_rdy        = m0_rsp_ready_i;
                end
                if (s_rsp_valid_i && rsp_rdy) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    assign s_rsp_ready_o = rsp_rdy;

    // Request fields are captured once at grant and held through REQ
    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= ARB_M0;
            rr_last  <= ARB_M1;
            s_addr_o <= '0;
            s_data_o <= '0;
            s_sel_o  <= '0;
            s_we_o   <= 1'b0;
        end else if (grant) begin
            owner   <= gnt_m1;
            rr_last <= gnt_m1;
            if (gnt_m1) begin
                s_addr_o <= m1_addr_i;
                s_data_o <= m1_data_i;
                s_sel_o  <= m1_sel_i;
                s_we_o   <= m1_we_i;
            end else begin
                s_addr_o <= m0_addr_i;
                s_data_o <= '0;
                s_sel_o  <= '0;
                s_we_o   <= 1'b0;
            end
        end
    end

`ifdef ROM_ARB_RR_EN
    assign starve_cnt = '0;
`else
    // Counts back-to-back fetch wins while the data port waits; never passes the limit
    // because reaching it hands the next tie to m1.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (gnt_m1 || !m1_req_valid_i)
                starve_cnt <= '0;
            else if ((STARVE_LIMIT > 0) && !starve)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(m0_req_ready_o && m1_req_ready_o));
            assert (!(m0_rsp_valid_o && m1_rsp_valid_o));
        end
    end

endmodule
